memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Parametrised RAM arbiter for the multi-core processor, replacing the single-core pass-through controller between the per-core caches and the shared RAM. It accepts instruction and data requests from `CPUS` cores, chooses one requester with a registered round-robin grant, and holds that grant until RAM completes the access. The caches see the same `iwait`/`dwait` stall handshake as before, now one handshake per core.

## Interface
Parameters:
- `CPUS`, default 2: number of cores, 1–8.
- `WORD_W`, default 32: address and data width in bits.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `iREN`  in  CPUS  per-core instruction read request.
- `dREN`, `dWEN`  in  CPUS each  per-core data read and data write request.
- `iaddr`, `daddr`, `dstore`  in  CPUS*WORD_W each  per-core instruction address, data address and write data. Core c occupies bits [c*WORD_W +: WORD_W].
- `iwait`, `dwait`  out  CPUS each  per-core stall; low for exactly the completing cycle.
- `iload`, `dload`  out  CPUS*WORD_W each  per-core read data; valid only while the matching wait bit is low.
- `ramREN`, `ramWEN`  out  1 each  RAM read and write strobes.
- `ramaddr`, `ramstore`  out  WORD_W each  RAM address and write data.
- `ramload`  in  WORD_W  RAM read data.
- `ramstate`  in  ramstate_t  RAM status: FREE, BUSY, ACCESS or ERROR.

## Operation
- Requesters: core c has an instruction slot (request = `iREN[c]`) and a data slot (request = `dREN[c] | dWEN[c]`). Within a core, the data slot beats the instruction slot.
- Round-robin pointer `rr` over cores, width `max(1,$clog2(CPUS))`, reset value 0.
  - The search starts at core `rr` and wraps modulo CPUS.
  - The first core with any request wins.
- FSM states:
  - IDLE: no grant; RAM strobes low. If any request is present, latch `gnt_core`/`gnt_data` and go to GRANT.
  - GRANT: drive RAM from the latched requester.
    - Data write: `ramWEN=1`, `ramaddr=daddr`, `ramstore=dstore`.
    - Data read: `ramREN=1`, `ramaddr=daddr`.
    - Instruction: `ramREN=1`, `ramaddr=iaddr`.
    - On `ramstate==ACCESS`, lower the granted wait bit and return read data on the granted load bus. Set `rr = gnt_core+1` (mod CPUS), then go to IDLE.
- Abort: if the granted request drops while in GRANT, go to IDLE with no completion and `rr` unchanged.
- `dWEN` with `dREN` on the same core is treated as a write.
- ERROR, BUSY and FREE all count as "not ACCESS"; the grant is held.
- Non-granted requesters see wait=1 and load=0.
- Ungranted outputs:
  - `ramaddr`/`ramstore` = 0 in IDLE.
  - All load buses = 0 except the granted one during completion.
- Reset values: FSM=IDLE, `rr`=0, `gnt_*`=0, all wait bits 1, all loads 0, `ramREN`=`ramWEN`=0, `ramaddr`=`ramstore`=0.

## Timing
- Cycle 0: request seen in IDLE. Cycle 1: GRANT, RAM driven from registered grant state. Earliest completion is cycle 1, with the wait bit low combinationally from `ramstate`.
- Cycle after completion: IDLE (mandatory one-cycle gap), then re-arbitration. Back-to-back throughput is one access per 2 cycles plus RAM latency.
- Requesters hold request, address and data stable until their wait bit is low.
- RAM outputs are stable for the whole GRANT residency.
- `RST` asserted in any state forces the reset values on the next edge. An in-flight access is dropped with no wait-low pulse.
- Simultaneous requests from all slots: at most one completion per GRANT. With rr=k, core k wins (data first).
- Starvation bound: a held request on core c completes within CPUS grants.

## Configuration
- `MEMARB_WRITE_PRIO_EN` defined: arbitration runs in two passes.
  - First, the round-robin search considers only cores with `dWEN` set.
  - If none, the normal search runs.
  - `rr` still advances to `gnt_core+1`.
- Undefined: the plain round-robin above applies.

## Test plan
- Reset: hold `RST` 2 cycles with all requests high. Outputs stay at reset values; the first GRANT is in the cycle after `RST` falls.
- Single read: core0 `iREN`, `iaddr`=0x40, `ramstate`=ACCESS on cycle 1, `ramload`=0xDEADBEEF. Then `ramREN`=1 with `ramaddr`=0x40 in cycle 1; `iwait[0]`=0 and `iload[0]`=0xDEADBEEF in cycle 1 only.
- Contention with CPUS=2: core0 `dREN` @0x100 and core1 `iREN` @0x200, both held, RAM BUSY 2 cycles then ACCESS. Grant order is core0 data, then core1 instruction; `rr` reads 1 then 0.
- Within-core priority: core1 `dWEN` @0x300 with `dstore`=0x12345678 and `iREN` together. The write is granted first (`ramWEN`=1, `ramstore`=0x12345678), then the instruction read.
- Abort and reset mid-GRANT:
  - Drop the granted `dREN` while `ramstate`=BUSY: IDLE next cycle, `rr` unchanged, no wait-low pulse.
  - Assert `RST` in GRANT: RAM strobes are 0 next cycle.
- `MEMARB_WRITE_PRIO_EN`: rr=0, core0 `iREN`, core1 `dWEN` @0x8. Core1 is granted first when the macro is defined, core0 when it is not.

Source files
------------

// File: rtl/memory_arbiter.sv
// Round-robin RAM arbiter: CPUS cores x {instruction, data} slots onto one shared RAM port.
// Optional MEMARB_WRITE_PRIO_EN: data writes win a first arbitration pass before the normal search.
module memory_arbiter #(
  parameter int unsigned CPUS   = 2,
  parameter int unsigned WORD_W = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*WORD_W-1:0]   iaddr,
  input  logic [CPUS*WORD_W-1:0]   daddr,
  input  logic [CPUS*WORD_W-1:0]   dstore,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*WORD_W-1:0]   iload,
  output logic [CPUS*WORD_W-1:0]   dload,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  logic [1:0]               ramstate
);

  localparam int unsigned CW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   gnt_core_q, gnt_core_d;
  logic            gnt_data_q, gnt_data_d;

  logic [CPUS-1:0] core_req;
  logic            arb_valid;
  logic [CW-1:0]   arb_core;
  logic            arb_data;
  logic            gnt_live;
  logic            in_grant;
  logic            done;
  logic [CW-1:0]   next_rr;
  logic [31:0]     gsel;

  // Core index k positions after base, wrapped modulo CPUS.
  function automatic logic [CW-1:0] rr_index(logic [CW-1:0] base, int unsigned k);
    int unsigned sum;
    sum = 32'(base) + k;
    if (sum >= CPUS) sum = sum - CPUS;
    return CW'(sum);
  endfunction

  assign core_req = iREN | dREN | dWEN;

  always_comb begin
    arb_valid = 1'b0;
    arb_core  = '0;
    arb_data  = 1'b0;
`ifdef MEMARB_WRITE_PRIO_EN
    for (int unsigned k = 0; k < CPUS; k++) begin
      if (!arb_valid && dWEN[rr_index(rr_q, k)]) begin
        arb_valid = 1'b1;
        arb_core  = rr_index(rr_q, k);
        arb_data  = 1'b1;
      end
    end
`endif
    for (int unsigned k = 0; k < CPUS; k++) begin
      if (!arb_valid && core_req[rr_index(rr_q, k)]) begin
        arb_valid = 1'b1;
        arb_core  = rr_index(rr_q, k);
        arb_data  = dREN[rr_index(rr_q, k)] | dWEN[rr_index(rr_q, k)];
      end
    end
  end

  assign gnt_live = gnt_data_q ? (dREN[gnt_core_q] | dWEN[gnt_core_q]) : iREN[gnt_core_q];
  assign in_grant = (state_q == StGrant) && gnt_live;
  assign done     = in_grant && (ramstate == ACCESS);
  assign next_rr  = (32'(gnt_core_q) == CPUS - 1) ? '0 : gnt_core_q + CW'(1);
  assign gsel     = 32'(gnt_core_q) * WORD_W;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    gnt_core_d = gnt_core_q;
    gnt_data_d = gnt_data_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          state_d    = StGrant;
          gnt_core_d = arb_core;
          gnt_data_d = arb_data;
        end
      end
      StGrant: begin
        // A dropped request aborts without advancing the pointer.
        if (!gnt_live) begin
          state_d = StIdle;
        end else if (done) begin
          state_d = StIdle;
          rr_d    = next_rr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    if (in_grant) begin
      if (gnt_data_q) begin
        ramaddr = daddr[gsel +: WORD_W];
        if (dWEN[gnt_core_q]) begin
          ramWEN   = 1'b1;
          ramstore = dstore[gsel +: WORD_W];
        end else begin
          ramREN = 1'b1;
        end
      end else begin
        ramREN  = 1'b1;
        ramaddr = iaddr[gsel +: WORD_W];
      end
    end
    if (done) begin
      if (gnt_data_q) begin
        dwait[gnt_core_q]     = 1'b0;
        dload[gsel +: WORD_W] = ramload;
      end else begin
        iwait[gnt_core_q]     = 1'b0;
        iload[gsel +: WORD_W] = ramload;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      rr_q       <= '0;
      gnt_core_q <= '0;
      gnt_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      gnt_core_q <= gnt_core_d;
      gnt_data_q <= gnt_data_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios then randomized traffic against a slot-level model.
`timescale 1ns/1ps
module tb_memory_arbiter;

  localparam int CPUS = 2;
  localparam int W    = 32;
  localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACCESS = 2'd2, R_ERROR = 2'd3;

  logic              clk = 1'b0;
  logic              rst;
  logic [CPUS-1:0]   iren, dren, dwen;
  logic [CPUS*W-1:0] iaddr, daddr, dstore;
  logic [CPUS-1:0]   iwait, dwait;
  logic [CPUS*W-1:0] iload, dload;
  logic              ramren, ramwen;
  logic [W-1:0]      ramaddr, ramstore, ramload;
  logic [1:0]        ramstate;

  always #5 clk = ~clk;

  memory_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (
    .CLK(clk), .RST(rst), .iREN(iren), .dREN(dren), .dWEN(dwen),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramren), .ramWEN(ramwen), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: which slot (if any) holds the grant, and the round-robin pointer.
  bit mbusy = 1'b0;
  int mgc   = 0;
  bit mgd   = 1'b0;
  int mrr   = 0;
  bit cyc_done;

  // Snapshot of DUT outputs from the most recent checked cycle.
  logic [CPUS-1:0]   o_iwait, o_dwait;
  logic [CPUS*W-1:0] o_iload, o_dload;
  logic              o_ren, o_wen;
  logic [W-1:0]      o_addr, o_store;
  int                o_rr;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void arb(output bit any, output int c, output bit d);
    any = 1'b0; c = 0; d = 1'b0;
`ifdef MEMARB_WRITE_PRIO_EN
    for (int k = 0; k < CPUS; k++) begin
      int idx;
      idx = (mrr + k) % CPUS;
      if (!any && dwen[idx]) begin any = 1'b1; c = idx; d = 1'b1; end
    end
`endif
    for (int k = 0; k < CPUS; k++) begin
      int idx;
      idx = (mrr + k) % CPUS;
      if (!any && (iren[idx] || dren[idx] || dwen[idx])) begin
        any = 1'b1; c = idx; d = dren[idx] | dwen[idx];
      end
    end
  endfunction

  // One clock: compare at negedge against the model, then advance the model at posedge.
  task automatic step();
    logic [CPUS-1:0]   e_iw, e_dw;
    logic [CPUS*W-1:0] e_il, e_dl;
    logic              e_ren, e_wen;
    logic [W-1:0]      e_addr, e_store;
    bit live, any, d;
    int c;
    @(negedge clk);
    e_iw = '1; e_dw = '1; e_il = '0; e_dl = '0;
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
    live = 1'b0; cyc_done = 1'b0;
    if (mbusy) begin
      live = mgd ? (dren[mgc] | dwen[mgc]) : iren[mgc];
      if (live) begin
        if (!mgd) begin
          e_ren = 1'b1; e_addr = iaddr[mgc*W +: W];
        end else if (dwen[mgc]) begin
          e_wen = 1'b1; e_addr = daddr[mgc*W +: W]; e_store = dstore[mgc*W +: W];
        end else begin
          e_ren = 1'b1; e_addr = daddr[mgc*W +: W];
        end
        if (ramstate == R_ACCESS) begin
          cyc_done = 1'b1;
          if (mgd) begin e_dw[mgc] = 1'b0; e_dl[mgc*W +: W] = ramload; end
          else     begin e_iw[mgc] = 1'b0; e_il[mgc*W +: W] = ramload; end
        end
      end
    end
    o_iwait = iwait; o_dwait = dwait; o_iload = iload; o_dload = dload;
    o_ren = ramren; o_wen = ramwen; o_addr = ramaddr; o_store = ramstore;
    o_rr = int'(dut.rr_q);
    check("iwait", iwait, e_iw);
    check("dwait", dwait, e_dw);
    check("iload", iload, e_il);
    check("dload", dload, e_dl);
    check("ramREN", ramren, e_ren);
    check("ramWEN", ramwen, e_wen);
    check("ramaddr", ramaddr, e_addr);
    check("ramstore", ramstore, e_store);
    check("rr", o_rr, mrr);
    @(posedge clk);
    if (rst) begin
      mbusy = 1'b0; mrr = 0;
    end else if (mbusy) begin
      if (cyc_done) begin mbusy = 1'b0; mrr = (mgc + 1) % CPUS; end
      else if (!live) mbusy = 1'b0;
    end else begin
      arb(any, c, d);
      if (any) begin mbusy = 1'b1; mgc = c; mgd = d; end
    end
    #1;
  endtask

  initial begin
    int r;
    rst = 1'b1; iren = '1; dren = '1; dwen = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = R_BUSY;
    @(posedge clk); #1;

    // Reset held with every slot requesting.
    step(); check("rst_strobes", {o_ren, o_wen}, 2'b00); check("rst_iwait", o_iwait, 2'b11);
    step(); check("rst_addr", o_addr, 32'h0);
    rst = 1'b0;
    step(); check("post_rst_idle", o_ren, 1'b0);
    step(); check("first_grant", o_ren, 1'b1);
    iren = '0; dren = '0;
    step(); step();

    // Contention: core0 data vs core1 instruction.
    dren[0] = 1'b1; daddr[0*W +: W] = 32'h100;
    iren[1] = 1'b1; iaddr[1*W +: W] = 32'h200;
    ramstate = R_BUSY; ramload = 32'hA5A5_0001;
    step();
    step(); check("cont_a_addr", o_addr, 32'h100);
    step();
    ramstate = R_ACCESS;
    step(); check("cont_a_done", o_dwait[0], 1'b0);
    dren[0] = 1'b0; ramstate = R_BUSY;
    step(); check("cont_rr1", o_rr, 1);
    step(); check("cont_b_addr", o_addr, 32'h200);
    step();
    ramstate = R_ACCESS;
    step(); check("cont_b_done", o_iwait[1], 1'b0);
    iren[1] = 1'b0;
    step(); check("cont_rr0", o_rr, 0);

    // Single instruction read.
    iren[0] = 1'b1; iaddr[0*W +: W] = 32'h40; ramload = 32'hDEAD_BEEF;
    step(); check("rd_c0_wait", o_iwait, 2'b11);
    step();
    check("rd_addr", o_addr, 32'h40);
    check("rd_wait", o_iwait[0], 1'b0);
    check("rd_data", o_iload[31:0], 32'hDEAD_BEEF);
    iren[0] = 1'b0;
    step(); check("rd_after", o_iwait[0], 1'b1);

    // Same-core write beats instruction read.
    dwen[1] = 1'b1; daddr[1*W +: W] = 32'h300; dstore[1*W +: W] = 32'h1234_5678;
    iren[1] = 1'b1; iaddr[1*W +: W] = 32'h304;
    step();
    step(); check("wr_wen", o_wen, 1'b1); check("wr_store", o_store, 32'h1234_5678);
    dwen[1] = 1'b0;
    step();
    step(); check("wr_then_rd", o_addr, 32'h304);
    iren[1] = 1'b0;
    step();

    // Abort: granted read dropped while RAM busy.
    dren[0] = 1'b1; daddr[0*W +: W] = 32'h500; ramstate = R_BUSY;
    step();
    step(); check("abort_grant", o_ren, 1'b1);
    dren[0] = 1'b0;
    step(); check("abort_nowait", o_dwait, 2'b11);
    step(); check("abort_idle", o_ren, 1'b0); check("abort_rr", o_rr, 0);

    // Reset while in GRANT; request stays up.
    dren[1] = 1'b1; daddr[1*W +: W] = 32'h600;
    step();
    step(); check("rstg_grant", o_ren, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(); check("rstg_dropped", {o_ren, o_wen}, 2'b00);
    ramstate = R_ACCESS;
    step(); check("rstg_regrant", o_dwait[1], 1'b0);
    dren[1] = 1'b0;
    step();

    // Write priority option: core0 instruction vs core1 write with rr=0.
    iren[0] = 1'b1; iaddr[0*W +: W] = 32'h44;
    dwen[1] = 1'b1; daddr[1*W +: W] = 32'h8; dstore[1*W +: W] = 32'hCAFE_F00D;
    step();
    step();
`ifdef MEMARB_WRITE_PRIO_EN
    check("wprio_first", o_addr, 32'h8);
    dwen[1] = 1'b0;
`else
    check("wprio_first", o_addr, 32'h44);
    iren[0] = 1'b0;
`endif
    step();
    step();
    iren = '0; dren = '0; dwen = '0;
    step();

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 9);
      ramstate = (r < 4) ? R_ACCESS : (r < 6) ? R_BUSY : (r < 8) ? R_FREE : R_ERROR;
      ramload = $urandom;
      for (int c = 0; c < CPUS; c++) begin
        bit gi, gdt;
        int k;
        gi  = mbusy && (mgc == c) && !mgd;
        gdt = mbusy && (mgc == c) && mgd;
        if (iren[c]) begin
          if ($urandom_range(0, 31) == 0 && !(gi && ramstate == R_ACCESS)) iren[c] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          iren[c] = 1'b1; iaddr[c*W +: W] = $urandom;
        end
        if (dren[c] || dwen[c]) begin
          if ($urandom_range(0, 31) == 0 && !(gdt && ramstate == R_ACCESS)) begin
            dren[c] = 1'b0; dwen[c] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          k = $urandom_range(0, 2);
          dren[c] = (k != 1); dwen[c] = (k != 0);
          daddr[c*W +: W] = $urandom; dstore[c*W +: W] = $urandom;
        end
      end
      step();
      if (cyc_done) begin
        if (mgd) begin dren[mgc] = 1'b0; dwen[mgc] = 1'b0; end
        else iren[mgc] = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
